// File: rtl/vga_timing_gen_if.sv
// vga_if: pixel-stream bundle shared by the draw stages.
// The timing generator drives it through the 'out' modport; downstream
// stages read it through 'sink'.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out  (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport sink (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: head of the pixel pipeline. It generates the h/v counters,
// sync and blanking strobes, line/frame start pulses and a frame counter.
// All strobes are decoded from the next-state counters and registered, so
// every field on 'out' describes the same pixel in the same cycle.
// Optional build macro VGA_TIMING_TEST_PATTERN_EN: drives eight vertical
// colour bars on rgb in the active area (otherwise rgb is constant black).
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.out          out,
    output logic        frame_start,
    output logic        line_start,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SY0  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SY1  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SY0  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SY1  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [10:0] h_cnt, v_cnt;
    logic [10:0] h_nxt, v_nxt;
    logic        h_wrap, v_wrap;
    logic        hsync_q, vsync_q, hblnk_q, vblnk_q;

    // Next-state counters; the frame boundary is both counters wrapping together.
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = h_wrap && (v_cnt == V_LAST);
        h_nxt  = h_wrap ? 11'd0 : h_cnt + 11'd1;
        v_nxt  = v_cnt;
        if (h_wrap)
            v_nxt = v_wrap ? 11'd0 : v_cnt + 11'd1;
    end

    // Counters and strobes, all registered from the next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            hblnk_q     <= 1'b0;
            vblnk_q     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            hblnk_q     <= (h_nxt >= H_ACT);
            hsync_q     <= (h_nxt >= H_SY0) && (h_nxt <= H_SY1);
            vblnk_q     <= (v_nxt >= V_ACT);
            vsync_q     <= (v_nxt >= V_SY0) && (v_nxt <= V_SY1);
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            frame_cnt   <= frame_cnt + {15'd0, v_wrap};
        end
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar_idx;
    logic [11:0] bar_rgb;
    logic [11:0] rgb_q;

    // Bar lookup for the pixel about to be shown; the last bar absorbs any remainder.
    always_comb begin
        bar_idx = ((int'(h_nxt) / BAR_W) > 7) ? 3'd7 : 3'(int'(h_nxt) / BAR_W);
        case (bar_idx)
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    end

    // Colour register, black during any blanking so it stays aligned with hblnk/vblnk.
    always_ff @(posedge clk) begin
        if (rst)
            rgb_q <= '0;
        else if ((h_nxt < H_ACT) && (v_nxt < V_ACT))
            rgb_q <= bar_rgb;
        else
            rgb_q <= '0;
    end

    assign out.rgb = rgb_q;
`else
    // Black is the "background not yet drawn" value for the downstream stages.
    assign out.rgb = 12'h000;
`endif

    assign out.hcount = h_cnt;
    assign out.vcount = v_cnt;
    assign out.hsync  = hsync_q;
    assign out.vsync  = vsync_q;
    assign out.hblnk  = hblnk_q;
    assign out.vblnk  = vblnk_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen with a reduced timing geometry so
// several frames fit in a short run. The reference model derives every
// field from the number of clock edges since reset was released.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HS = 4, HB = 2;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
        logic        fs, ls;
        logic [15:0] fc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start, line_start;
    logic [15:0] frame_cnt;

    vga_if vif ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .out        (vif),
        .frame_start(frame_start),
        .line_start (line_start),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   t_run    = 0;
    int   n_pushed = 0;
    int   n_popped = 0;

    // Expected outputs after t edges with reset low.
    function automatic obs_t model(input int t);
        obs_t e;
        int   h, v;
        logic [11:0] bars [8];
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        h    = t % HT;
        v    = (t / HT) % VT;
        e.h  = 11'(h);
        e.v  = 11'(v);
        e.hb = (h >= HA);
        e.hs = (h >= HA + HF) && (h < HA + HF + HS);
        e.vb = (v >= VA);
        e.vs = (v >= VA + VF) && (v < VA + VF + VS);
        e.ls = (t > 0) && (h == 0);
        e.fs = (t > 0) && (t % FT == 0);
        e.fc = 16'(t / FT);
        e.rgb = 12'h000;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        if (!e.hb && !e.vb)
            e.rgb = bars[h / (HA / 8)];
`endif
        return e;
    endfunction

    // Reference: one expected observation per clock edge.
    always @(posedge clk) begin
        if (rst) begin
            t_run = 0;
            exp_q.push_back('0);
        end else begin
            t_run = t_run + 1;
            exp_q.push_back(model(t_run));
        end
        n_pushed = n_pushed + 1;
    end

    // Monitor: outputs are valid every cycle, compared away from the edge.
    always @(negedge clk) begin
        obs_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_popped = n_popped + 1;
            a.h   = vif.hcount;
            a.v   = vif.vcount;
            a.hs  = vif.hsync;
            a.vs  = vif.vsync;
            a.hb  = vif.hblnk;
            a.vb  = vif.vblnk;
            a.rgb = vif.rgb;
            a.fs  = frame_start;
            a.ls  = line_start;
            a.fc  = frame_cnt;
            n_checks = n_checks + 1;
            if (a !== e) begin
                n_errors = n_errors + 1;
                $display("FAIL pixel t=%0d rst=%0b: got h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b rgb=%h fs=%0b ls=%0b fc=%0d, want h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b rgb=%h fs=%0b ls=%0b fc=%0d",
                         t_run, rst, a.h, a.v, a.hs, a.vs, a.hb, a.vb, a.rgb, a.fs, a.ls, a.fc,
                         e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.rgb, e.fs, e.ls, e.fc);
            end
        end
    end

    initial begin
        int len;
        // Reset held for three cycles, then a run spanning three full frames.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3 * FT + 5) @(negedge clk);

        // Randomized segments of free running with mid-frame reset pulses.
        for (int seg = 0; seg < 12; seg++) begin
            rst = 1'b1;
            len = $urandom_range(1, 3);
            repeat (len) @(negedge clk);
            rst = 1'b0;
            len = $urandom_range(1, 2 * FT);
            repeat (len) @(negedge clk);
        end

        // Reset landing on the last pixel of a frame, then one more frame.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (FT - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (FT + 3) @(negedge clk);

        @(negedge clk);
        #1;
        n_checks = n_checks + 1;
        if (exp_q.size() != 0 || n_popped != n_pushed) begin
            n_errors = n_errors + 1;
            $display("FAIL scoreboard_drain: got %0d left (%0d popped), want 0 left (%0d popped)",
                     exp_q.size(), n_popped, n_pushed);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
